// File: rtl/field_fetch.sv
// MIX operand field fetch: reads one memory word, masks bytes L..R and the sign, and right-aligns the field.
// Define FIELD_FETCH_CHECK_EN to reject fields with L>R or R>5 without a memory read (field_err=1).
module field_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] addr,
  input  logic [5:0]  field,
  output logic        busy,
  output logic        mem_rd,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [30:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] operand,
  output logic        field_err
);

  typedef enum logic [1:0] {IDLE, READ, SHIFT, HOLD} state_t;

  state_t      state, state_nx;
  logic [11:0] addr_q, addr_nx;
  logic [5:0]  field_q, field_nx;
  logic [30:0] word_q, word_nx;
  logic [2:0]  cnt_q, cnt_nx;
  logic        err_q, err_nx;

  logic [2:0]  fl, fr, l_eff, r_eff;
  logic [30:0] masked;
  logic        field_bad;

  assign fl    = field_q[5:3];
  assign fr    = field_q[2:0];
  // Byte positions run 1..5; L=0 only selects the sign, and R above 5 saturates.
  assign l_eff = (fl == 3'd0) ? 3'd1 : fl;
  assign r_eff = (fr > 3'd5) ? 3'd5 : fr;

`ifdef FIELD_FETCH_CHECK_EN
  assign field_bad = (field[5:3] > field[2:0]) || (field[2:0] > 3'd5);
`else
  assign field_bad = 1'b0;
`endif

  always_comb begin
    masked     = '0;
    masked[30] = mem_data[30] & (fl == 3'd0);
    for (int i = 1; i <= 5; i++) begin
      if (3'(i) >= l_eff && 3'(i) <= r_eff)
        masked[6*(5-i) +: 6] = mem_data[6*(5-i) +: 6];
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_nx = state;
    addr_nx  = addr_q;
    field_nx = field_q;
    word_nx  = word_q;
    cnt_nx   = cnt_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nx  = addr;
          field_nx = field;
          word_nx  = '0;
          cnt_nx   = 3'd0;
          err_nx   = field_bad;
          state_nx = field_bad ? HOLD : READ;
        end
      end
      READ: begin
        if (mem_ack) begin
          word_nx = masked;
          if (r_eff == 3'd5) begin
            state_nx = HOLD;
          end else begin
            cnt_nx   = 3'd5 - r_eff;
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        word_nx = {word_q[30], 6'd0, word_q[29:6]};
        cnt_nx  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_nx = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          err_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      field_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      field_q <= field_nx;
      word_q  <= word_nx;
      cnt_q   <= cnt_nx;
      err_q   <= err_nx;
    end
  end

  assign busy      = (state != IDLE);
  assign mem_rd    = (state == READ);
  assign mem_addr  = addr_q;
  assign out_valid = (state == HOLD);
  assign operand   = out_valid ? word_q : '0;

`ifdef FIELD_FETCH_CHECK_EN
  assign field_err = out_valid & err_q;
`else
  assign field_err = 1'b0;
`endif

endmodule

// File: tb/tb_field_fetch.sv
// Directed self-checking bench for field_fetch; expectations follow FIELD_FETCH_CHECK_EN when defined.
module tb_field_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] addr;
  logic [5:0]  field;
  logic        busy;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [30:0] mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] operand;
  logic        field_err;

  int n_checks = 0;
  int n_pass   = 0;

  // sign=1, bytes 1..5 = 1,2,3,4,5
  localparam logic [30:0] WORD = 31'h4108_3105;

  field_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr      (addr),
    .field     (field),
    .busy      (busy),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operand   (operand),
    .field_err (field_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One full fetch; inputs change on the falling edge and outputs are sampled there too.
  task automatic run_fetch(input string tag, input logic [11:0] a, input logic [5:0] f,
                           input int ack_wait, input logic [30:0] exp_op,
                           input logic exp_err, input int exp_lat, input logic hold_test);
    int cycles;
    @(negedge clk);
    start = 1'b1; addr = a; field = f; mem_data = WORD;
    @(negedge clk);
    start = 1'b0; addr = 12'h000; field = 6'd0;
    if (exp_err) begin
      check({tag, "_err_nord"}, mem_rd, 1'b0);
      check({tag, "_err_valid"}, out_valid, 1'b1);
    end else begin
      check({tag, "_rd"}, mem_rd, 1'b1);
      check({tag, "_maddr"}, mem_addr, a);
      check({tag, "_op_read0"}, operand, 31'd0);
      repeat (ack_wait) @(negedge clk);
      check({tag, "_rd_wait"}, mem_rd, 1'b1);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < 20) begin
        cycles++;
        @(negedge clk);
      end
      check({tag, "_lat"}, cycles, exp_lat);
      check({tag, "_rd_done"}, mem_rd, 1'b0);
    end
    check({tag, "_op"}, operand, exp_op);
    check({tag, "_ferr"}, field_err, exp_err);
    if (hold_test) begin
      for (int k = 0; k < 4; k++) begin
        start = (k < 2); addr = 12'hfff; field = 6'd5;
        @(negedge clk);
        check({tag, "_hold_valid"}, out_valid, 1'b1);
        check({tag, "_hold_op"}, operand, exp_op);
        check({tag, "_hold_nord"}, mem_rd, 1'b0);
      end
      start = 1'b1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_op"}, operand, 31'd0);
    check({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addr = '0; field = '0;
    mem_ack = 1'b0; mem_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rd", mem_rd, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ferr", field_err, 1'b0);
    check("rst_op", operand, 31'd0);
    check("rst_maddr", mem_addr, 12'd0);
    rst = 1'b0;

    run_fetch("f0_5",  12'h123, 6'd5,  2, WORD,          1'b0, 0, 1'b0);
    run_fetch("f1_5",  12'h456, 6'd13, 2, 31'h0108_3105, 1'b0, 0, 1'b0);
    run_fetch("f3_3",  12'h789, 6'd27, 1, 31'h0000_0003, 1'b0, 2, 1'b0);
    run_fetch("f0_0",  12'h00a, 6'd0,  0, 31'h4000_0000, 1'b0, 5, 1'b0);
    run_fetch("f1_2",  12'h7ff, 6'd10, 3, 31'h0000_0042, 1'b0, 3, 1'b0);
    run_fetch("f5_5",  12'h800, 6'd45, 1, 31'h0000_0005, 1'b0, 0, 1'b0);
    run_fetch("hold",  12'h321, 6'd27, 2, 31'h0000_0003, 1'b0, 2, 1'b1);
`ifdef FIELD_FETCH_CHECK_EN
    run_fetch("f4_2",  12'h111, 6'd34, 0, 31'd0,         1'b1, 0, 1'b0);
    run_fetch("f0_7",  12'h222, 6'd7,  0, 31'd0,         1'b1, 0, 1'b0);
`else
    run_fetch("f4_2",  12'h111, 6'd34, 1, 31'd0,         1'b0, 3, 1'b0);
    run_fetch("f0_7",  12'h222, 6'd7,  1, WORD,          1'b0, 0, 1'b0);
`endif

    // Reset in the middle of READ, then a stray acknowledge in IDLE.
    @(negedge clk);
    start = 1'b1; addr = 12'habc; field = 6'd5;
    @(negedge clk);
    start = 1'b0;
    check("rread_rd", mem_rd, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rread_rd_async", mem_rd, 1'b0);
    check("rread_busy", busy, 1'b0);
    check("rread_maddr", mem_addr, 12'd0);
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_ack_valid", out_valid, 1'b0);
      check("late_ack_busy", busy, 1'b0);
      check("late_ack_rd", mem_rd, 1'b0);
    end
    mem_ack = 1'b0;

    // Reset in the middle of SHIFT.
    @(negedge clk);
    start = 1'b1; addr = 12'h0f0; field = 6'd0;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("rshift_busy_pre", busy, 1'b1);
    check("rshift_valid_pre", out_valid, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rshift_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rshift_valid", out_valid, 1'b0);
    check("rshift_op", operand, 31'd0);

    // A fetch after the aborted ones still works.
    run_fetch("after", 12'h555, 6'd27, 0, 31'h0000_0003, 1'b0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
